// File: rtl/seven_seg_scan_driver.sv
// Purpose : reassemble a multiplexed BCD digit stream into a 4-digit frame and scan it
//           onto a common-anode 7-segment display (LZB, invalid-code dash, dead time).
// Latency : one clock from scan_idx/shadow to the pins; a frame commits on its slot-3 capture.
// Backpres: none; the stream is sampled on every clock with stream_en=1 and never stalled.
// Ports   : clk, rst (sync, active high); digit_in/digit_sel/stream_en = incoming stream;
//           blank forces the display dark; an_n/seg_n/dp_n = display pins (active low);
//           frame_valid = at least one complete frame has been latched since reset.
module seven_seg_scan_driver #(
  parameter int SCAN_DIV = 50,
  parameter int SEL_SKEW = 1,
  parameter bit LZB_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic [1:0] digit_sel,
  input  logic       stream_en,
  input  logic       blank,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_valid
);

  localparam int          PW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_TC = PW'(SCAN_DIV - 1);
  localparam logic [1:0]  SKEW_L = 2'(SEL_SKEW);

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      scan_idx_q, scan_idx_d;
  logic [3:0][3:0] cap_q, cap_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      mask_q, mask_d;
  logic            frame_valid_q, frame_valid_d;
  logic [3:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;

  logic [1:0] slot;
  logic [2:0] next_slot;   // lowest unset mask bit; 4 means the mask is full
  logic       dark;
  logic       lz_blank;
  logic [3:0] cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Stream capture and frame assembly.
  always_comb begin
    slot          = digit_sel - SKEW_L;
    next_slot     = 3'd4;
    cap_d         = cap_q;
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    frame_valid_d = frame_valid_q;
    for (int i = 3; i >= 0; i--) begin
      if (!mask_q[i]) next_slot = 3'(i);
    end
    if (stream_en) begin
      cap_d[slot] = digit_in;
      if (slot == 2'd3 && mask_q[2:0] == 3'b111) begin
        // Whole frame moves in one edge so the scan never shows two frames mixed.
        shadow_d      = {digit_in, cap_q[2], cap_q[1], cap_q[0]};
        mask_d        = 4'b0000;
        frame_valid_d = 1'b1;
      end else if ({1'b0, slot} == next_slot) begin
        mask_d[slot] = 1'b1;
      end else begin
        // Out-of-order slot: restart assembly from this slot.
        mask_d = 4'b0001 << slot;
      end
    end
  end

  // Free-running scan timebase; it keeps running while dark so re-enabling is glitch-free.
  always_comb begin
    presc_d    = presc_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (presc_q == P_TC) begin
      presc_d    = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  // Output pattern for the next clock.
  always_comb begin
    cur_digit = shadow_q[scan_idx_q];
    lz_blank  = LZB_EN && (scan_idx_q != 2'd0);
    for (int i = 1; i < 4; i++) begin
      if (i >= int'(scan_idx_q) && shadow_q[i] != 4'd0) lz_blank = 1'b0;
    end
    // presc_q==0 is the first clock of a digit: dead time against ghosting.
    dark    = blank || !frame_valid_q || (presc_q == '0);
    an_n_d  = dark ? 4'b1111 : ~(4'b0001 << scan_idx_q);
    seg_n_d = (dark || lz_blank) ? 7'b1111111 : decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      scan_idx_q    <= 2'd0;
      cap_q         <= '0;
      shadow_q      <= '0;
      mask_q        <= 4'b0000;
      frame_valid_q <= 1'b0;
      an_n_q        <= 4'b1111;
      seg_n_q       <= 7'b1111111;
    end else begin
      presc_q       <= presc_d;
      scan_idx_q    <= scan_idx_d;
      cap_q         <= cap_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      frame_valid_q <= frame_valid_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = 1'b1;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios with literal expectations plus a
// randomized stream, all checked every clock against a time-based behavioural model.
module tb_seven_seg_scan_driver;

  localparam int SD   = 4;
  localparam int SKEW = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic [1:0] digit_sel = '0;
  logic       stream_en = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_valid;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scan_driver #(.SCAN_DIV(SD), .SEL_SKEW(SKEW), .LZB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_sel(digit_sel),
    .stream_en(stream_en), .blank(blank), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scan position is derived purely from the clock count since reset.
  int  m_t;
  int  m_cap[4];
  int  m_sh[4];
  bit  m_mask[4];
  bit  m_fv;
  bit  model_ok = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_fv;

  function automatic logic [6:0] pattern(input int v);
    logic [6:0] tbl[10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 9) return 7'b0111111;
    return tbl[v];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_fv = 0;
      for (int i = 0; i < 4; i++) begin m_cap[i] = 0; m_sh[i] = 0; m_mask[i] = 0; end
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_fv = 1'b0;
      model_ok = 1'b1;
    end else begin
      int idx, ph, slot, low;
      bit dark, lzb;
      idx  = (m_t / SD) % 4;
      ph   = m_t % SD;
      dark = blank || !m_fv || (ph == 0);
      lzb  = (idx != 0);
      for (int j = idx; j < 4; j++) if (m_sh[j] != 0) lzb = 0;
      exp_an  = dark ? 4'b1111 : 4'((~(1 << idx)) & 15);
      exp_seg = (dark || lzb) ? 7'b1111111 : pattern(m_sh[idx]);
      if (stream_en) begin
        slot = (int'(digit_sel) - SKEW + 4) % 4;
        if (slot == 3 && m_mask[0] && m_mask[1] && m_mask[2]) begin
          for (int j = 0; j < 3; j++) m_sh[j] = m_cap[j];
          m_sh[3] = digit_in;
          for (int j = 0; j < 4; j++) m_mask[j] = 0;
          m_fv = 1;
        end else begin
          low = 4;
          for (int j = 3; j >= 0; j--) if (!m_mask[j]) low = j;
          if (slot != low) for (int j = 0; j < 4; j++) m_mask[j] = 0;
          m_mask[slot] = 1;
        end
        m_cap[slot] = digit_in;
      end
      exp_fv = m_fv;
      m_t++;
    end
  end

  // Compare process: every clock, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("an_n", 16'(an_n), 16'(exp_an));
      chk("seg_n", 16'(seg_n), 16'(exp_seg));
      chk("frame_valid", 16'(frame_valid), 16'(exp_fv));
      chk("dp_n", 16'(dp_n), 16'h1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_slot(input int s, input int v);
    @(negedge clk);
    stream_en = 1'b1;
    digit_sel = 2'((s + SKEW) % 4);
    digit_in  = 4'(v);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    stream_en = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  // Arguments are thousands..ones; streamed ones first.
  task automatic send_frame(input int d3, input int d2, input int d1, input int d0);
    send_slot(0, d0); send_slot(1, d1); send_slot(2, d2); send_slot(3, d3);
    idle(2);
  endtask

  // Wait (bounded) for digit idx to be lit, then check its segment pattern.
  task automatic expect_digit(input string nm, input int idx, input logic [6:0] exp);
    logic [3:0] a;
    bit found = 0;
    a = 4'b0001 << idx;
    a = ~a;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (an_n === a) found = 1;
    end
    if (found) chk(nm, 16'(seg_n), 16'(exp));
    else begin
      n_cmp++; n_err++;
      $display("FAIL %s: anode %b never active (got %b)", nm, a, an_n);
    end
  endtask

  initial begin
    int k;
    bit lit;
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an_n), 16'hF);
    chk("rst_seg", 16'(seg_n), 16'h7F);
    chk("rst_fv", 16'(frame_valid), 16'h0);
    rst = 1'b0;
    idle(6);
    chk("dark_before_frame", 16'(an_n), 16'hF);

    // 1: frame 1,0,3,7 (thousands..ones)
    send_frame(1, 0, 3, 7);
    chk("fv_after_frame", 16'(frame_valid), 16'h1);
    expect_digit("t1_d0", 0, 7'b1111000);
    expect_digit("t1_d1", 1, 7'b0110000);
    expect_digit("t1_d2", 2, 7'b1000000);
    expect_digit("t1_d3", 3, 7'b1111001);

    // 2: leading-zero blanking
    send_frame(0, 0, 4, 0);
    expect_digit("t2_d3", 3, 7'b1111111);
    expect_digit("t2_d2", 2, 7'b1111111);
    expect_digit("t2_d1", 1, 7'b0011001);
    expect_digit("t2_d0", 0, 7'b1000000);
    send_frame(0, 0, 0, 0);
    expect_digit("t2_z1", 1, 7'b1111111);
    expect_digit("t2_z0", 0, 7'b1000000);

    // 3: invalid code shows a dash and counts as nonzero
    send_frame(0, 0, 12, 5);
    expect_digit("t3_d1", 1, 7'b0111111);
    expect_digit("t3_d2", 2, 7'b1111111);
    expect_digit("t3_d0", 0, 7'b0010010);

    // 4: broken order 0,1,3 must not commit
    send_slot(0, 8); send_slot(1, 8); send_slot(3, 8);
    idle(2);
    expect_digit("t4_keep", 1, 7'b0111111);
    send_frame(6, 2, 9, 8);
    expect_digit("t4_new3", 3, 7'b0000010);
    expect_digit("t4_new1", 1, 7'b0010000);

    // 5: blank mid-scan
    @(negedge clk);
    blank = 1'b1;
    lit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an_n !== 4'b1111) lit = 1;
    end
    chk("t5_blank_dark", 16'(lit), 16'h0);
    blank = 1'b0;
    idle(10);

    // 6: reset while digit2 is displayed
    expect_digit("t6_d2", 2, 7'b0100100);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_an", 16'(an_n), 16'hF);
    chk("t6_seg", 16'(seg_n), 16'h7F);
    chk("t6_fv", 16'(frame_valid), 16'h0);
    rst = 1'b0;
    idle(20);
    chk("t6_still_dark", 16'(an_n), 16'hF);
    send_frame(0, 0, 0, 1);
    expect_digit("t6_refill", 0, 7'b1111001);

    // Randomized stream
    k = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 599) == 0);
      stream_en = ($urandom_range(0, 7) != 0);
      digit_sel = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'(k % 4);
      k++;
      digit_in  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
      blank     = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst = 1'b0; stream_en = 1'b0; blank = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
